// File: rtl/ula_pkg.sv
// Shared constants, result bundle type and overflow helper for the registered
// 8-bit 74181-style ALU.
package ula_pkg;

  localparam int SLICE_W = 4;
  localparam int DATA_W  = 8;

  localparam logic [3:0] S_ADD       = 4'b1001;
  localparam logic [3:0] S_SUB       = 4'b0110;
  localparam logic [3:0] S_LOGIC_XOR = 4'b0110;

  localparam logic M_LOGIC = 1'b1;
  localparam logic M_ARITH = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic              a_eq_b;
    logic              c_out;
    logic              overflow;
    logic              p;
    logic              g;
  } alu_out_t;

  // Signed overflow is only meaningful for the true add and subtract encodings.
  function automatic logic signed_overflow(
    input logic [3:0] s,
    input logic       m,
    input logic       a_msb,
    input logic       b_msb,
    input logic       f_msb
  );
    logic ov;
    ov = 1'b0;
    if (m == M_ARITH) begin
      case (s)
        S_ADD:   ov = (a_msb == b_msb) && (f_msb != a_msb);
        S_SUB:   ov = (a_msb != b_msb) && (f_msb == b_msb);
        default: ov = 1'b0;
      endcase
    end else begin
      ov = 1'b0;
    end
    return ov;
  endfunction

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181-style slice with active-high carry and group
// propagate/generate outputs.
module ula_74181
  import ula_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         s,
  input  logic               m,
  input  logic               c_in,
  output logic [SLICE_W-1:0] f,
  output logic               a_eq_b,
  output logic               c_out,
  output logic               p,
  output logic               g
);

  logic [SLICE_W-1:0] t1;
  logic [SLICE_W-1:0] t2;
  logic [SLICE_W:0]   sum;

  // Per-bit propagate/generate terms, slice sum and lookahead outputs.
  always_comb begin
    t1  = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
    t2  = (a & ~b & {SLICE_W{s[2]}}) | (a & b & {SLICE_W{s[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {{SLICE_W{1'b0}}, c_in};
    if (m == M_LOGIC) begin
      f = ~(t1 ^ t2);
    end else begin
      f = sum[SLICE_W-1:0];
    end
    c_out  = sum[SLICE_W];
    p      = &t1;
    g      = t2[3] | (t1[3] & t2[2]) | (t1[3] & t1[2] & t2[1])
           | (t1[3] & t1[2] & t1[1] & t2[0]);
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_8bit_reg.sv
// Registered 8-bit ALU: two rippled 74181 slices, group P/G merge, signed
// overflow detection and a one-cycle output register.
module ula_8bit_reg
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        s,
  input  logic              m,
  input  logic              c_in,
  output logic [DATA_W-1:0] f,
  output logic              a_eq_b,
  output logic              c_out,
  output logic              overflow,
  output logic              p,
  output logic              g
);

  logic [SLICE_W-1:0] f_lo, f_hi;
  logic               eq_lo, eq_hi;
  logic               c_lo, c_hi;
  logic               p_lo, p_hi;
  logic               g_lo, g_hi;
  alu_out_t           nxt;
  alu_out_t           q;

  ula_74181 u_lo (
    .a      (a[SLICE_W-1:0]),
    .b      (b[SLICE_W-1:0]),
    .s      (s),
    .m      (m),
    .c_in   (c_in),
    .f      (f_lo),
    .a_eq_b (eq_lo),
    .c_out  (c_lo),
    .p      (p_lo),
    .g      (g_lo)
  );

  ula_74181 u_hi (
    .a      (a[DATA_W-1:SLICE_W]),
    .b      (b[DATA_W-1:SLICE_W]),
    .s      (s),
    .m      (m),
    .c_in   (c_lo),
    .f      (f_hi),
    .a_eq_b (eq_hi),
    .c_out  (c_hi),
    .p      (p_hi),
    .g      (g_hi)
  );

  // Merge the two slices into the next registered result.
  always_comb begin
    nxt.f        = {f_hi, f_lo};
    nxt.a_eq_b   = eq_lo & eq_hi;
    nxt.c_out    = c_hi;
    nxt.p        = p_lo & p_hi;
    nxt.g        = g_hi | (p_hi & g_lo);
    nxt.overflow = signed_overflow(s, m, a[DATA_W-1], b[DATA_W-1], nxt.f[DATA_W-1]);
  end

  // Output register; reset wins over any operation in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign f        = q.f;
  assign a_eq_b   = q.a_eq_b;
  assign c_out    = q.c_out;
  assign overflow = q.overflow;
  assign p        = q.p;
  assign g        = q.g;

endmodule

// File: tb/tb_ula_8bit_reg.sv
// Directed and swept checks of ula_8bit_reg against hand values and a
// bit-serial reference model.
module tb_ula_8bit_reg;
  import ula_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] s;
  logic       m, c_in;
  logic [7:0] f;
  logic       a_eq_b, c_out, overflow, p, g;

  int n_cmp;
  int n_err;

  ula_8bit_reg dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
    .f(f), .a_eq_b(a_eq_b), .c_out(c_out), .overflow(overflow), .p(p), .g(g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ai, input logic [7:0] bi, input logic [3:0] si,
                       input logic mi, input logic ci);
    @(negedge clk);
    a = ai; b = bi; s = si; m = mi; c_in = ci;
  endtask

  task automatic step(input logic [7:0] ai, input logic [7:0] bi, input logic [3:0] si,
                      input logic mi, input logic ci);
    drive(ai, bi, si, mi, ci);
    @(posedge clk);
    #1;
  endtask

  // Bit-serial model: {f, a_eq_b, c_out, overflow, p, g}
  function automatic logic [12:0] model(input logic [7:0] ai, input logic [7:0] bi,
                                        input logic [3:0] si, input logic mi, input logic ci);
    logic [7:0] t1, t2, fo;
    logic       cy, gg, pp, ov;
    cy = ci; gg = 1'b0; pp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      t1[i] = ai[i] | (bi[i] & si[0]) | (~bi[i] & si[1]);
      t2[i] = (ai[i] & ~bi[i] & si[2]) | (ai[i] & bi[i] & si[3]);
      fo[i] = mi ? ~(t1[i] ^ t2[i]) : (t1[i] ^ t2[i] ^ cy);
      cy    = (t1[i] & t2[i]) | (t1[i] & cy) | (t2[i] & cy);
      gg    = t2[i] | (t1[i] & gg);
      pp    = pp & t1[i];
    end
    ov = 1'b0;
    if (!mi && si == 4'b1001) ov = (ai[7] == bi[7]) && (fo[7] != ai[7]);
    if (!mi && si == 4'b0110) ov = (ai[7] != bi[7]) && (fo[7] == bi[7]);
    return {fo, &fo, cy, ov, pp, gg};
  endfunction

  logic [7:0] va [6] = '{8'h00, 8'hFF, 8'h00, 8'hAA, 8'h0F, 8'hFF};
  logic [7:0] vb [6] = '{8'h00, 8'h00, 8'hFF, 8'h55, 8'hF0, 8'hFF};

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; a = 8'h00; b = 8'h00; s = 4'h0; m = 1'b0; c_in = 1'b0;
    step(8'h5A, 8'h3C, 4'hF, 1'b1, 1'b0);
    chk("reset", {3'b0, f, a_eq_b, c_out, overflow, p, g}, 16'h0000);
    rst = 1'b0;

    step(8'h0F, 8'h01, S_ADD, M_ARITH, 1'b0);
    chk("add_ripple_f", {8'h0, f}, 16'h0010);
    chk("add_ripple_c", {15'h0, c_out}, 16'h0000);
    chk("add_ripple_ov", {15'h0, overflow}, 16'h0000);

    step(8'h7F, 8'h01, S_ADD, M_ARITH, 1'b0);
    chk("add_ovf_f", {8'h0, f}, 16'h0080);
    chk("add_ovf_ov_c", {14'h0, overflow, c_out}, 16'h0002);

    step(8'h80, 8'h80, S_ADD, M_ARITH, 1'b0);
    chk("add_neg_f", {8'h0, f}, 16'h0000);
    chk("add_neg_ov_c", {14'h0, overflow, c_out}, 16'h0003);

    step(8'h80, 8'h01, S_SUB, M_ARITH, 1'b1);
    chk("sub_ovf_f", {8'h0, f}, 16'h007F);
    chk("sub_ovf_ov_c", {14'h0, overflow, c_out}, 16'h0003);

    step(8'h55, 8'h55, S_SUB, M_ARITH, 1'b0);
    chk("sub_eq_f", {8'h0, f}, 16'h00FF);
    chk("sub_eq_eq_c", {14'h0, a_eq_b, c_out}, 16'h0002);

    step(8'hAA, 8'h55, S_LOGIC_XOR, M_LOGIC, 1'b0);
    chk("xor_f", {8'h0, f}, 16'h00FF);
    chk("xor_eq_ov", {14'h0, a_eq_b, overflow}, 16'h0002);

    step(8'h0F, 8'h00, 4'h0, M_LOGIC, 1'b0);
    chk("not_a", {8'h0, f}, 16'h00F0);

    step(8'hAA, 8'h0F, 4'hB, M_LOGIC, 1'b1);
    chk("and_ab", {8'h0, f}, 16'h000A);

    step(8'h00, 8'h00, 4'hF, M_ARITH, 1'b0);
    chk("a_minus_1", {8'h0, f}, 16'h00FF);
    chk("a_minus_1_flags", {11'h0, a_eq_b, c_out, overflow, p, g}, 16'h0012);

    step(8'hFF, 8'h00, S_ADD, M_ARITH, 1'b0);
    chk("pg_prop", {14'h0, p, g}, 16'h0002);

    // One-cycle latency: new inputs must not show until the next edge.
    step(8'hFF, 8'h00, S_ADD, M_ARITH, 1'b1);
    chk("pg_cin_f_c", {7'h0, f, c_out}, 16'h0001);
    drive(8'h12, 8'h34, S_ADD, M_ARITH, 1'b0);
    #1;
    chk("latency_hold", {7'h0, f, c_out}, 16'h0001);
    @(posedge clk); #1;
    chk("latency_update", {8'h0, f}, 16'h0046);

    // Mid-stream reset overrides the operation presented with it.
    drive(8'h7F, 8'h01, S_ADD, M_ARITH, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset", {3'b0, f, a_eq_b, c_out, overflow, p, g}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset", {8'h0, f}, 16'h0080);

    for (int mi = 0; mi < 2; mi++) begin
      for (int si = 0; si < 16; si++) begin
        for (int ci = 0; ci < 2; ci++) begin
          for (int vi = 0; vi < 6; vi++) begin
            step(va[vi], vb[vi], 4'(si), 1'(mi), 1'(ci));
            chk($sformatf("sweep m%0d s%0h c%0d v%0d", mi, si, ci, vi),
                {3'b0, f, a_eq_b, c_out, overflow, p, g},
                {3'b0, model(va[vi], vb[vi], 4'(si), 1'(mi), 1'(ci))});
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
